intr_receiver: RTL and testbench

INTR_RECEIVER -- requirements
Module: intr_receiver

---
 rtl/intr_pkg.sv | 16 +
 rtl/intr_sync.sv | 30 +++
 rtl/intr_receiver.sv | 128 ++++++++++++
 tb/tb_intr_receiver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the interrupt receiver.
//   state_t            - request/acknowledge FSM states
//   DEF_MIN_PULSE      - default minimum qualified pulse width (CLK cycles)
//   DEF_CNT_W          - default width of the pending-event counter
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam int DEF_MIN_PULSE = 3;
  localparam int DEF_CNT_W     = 2;

endpackage

// File: rtl/intr_sync.sv
// intr_sync: two-flop synchronizer for a single asynchronous bit.
//   CLK - destination clock
//   RST - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output, two CLK edges behind d
module intr_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage p0: first capture, may go metastable
      sync_p0 <= d;
      // stage p1: settled copy
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/intr_receiver.sv
// intr_receiver: qualifies button interrupt pulses, counts pending events
// and hands them to the CPU through an IRQ/ACK handshake.
//   CLK      - system clock, rising edge
//   RST      - asynchronous active-high reset
//   INTR     - asynchronous interrupt pulse
//   INT_EN   - CPU interrupt enable
//   INT_ACK  - single-cycle CPU acknowledge
//   IRQ      - registered interrupt request (high only in ST_REQ)
//   PEND_CNT - accepted, not yet acknowledged events (saturating)
//   OVF      - sticky: an event arrived while PEND_CNT was saturated
module intr_receiver
  import intr_pkg::*;
#(
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR,
  input  logic             INT_EN,
  input  logic             INT_ACK,
  output logic             IRQ,
  output logic [CNT_W-1:0] PEND_CNT,
  output logic             OVF
);

  localparam int WW = $clog2(MIN_PULSE + 1);
  localparam logic [WW-1:0]    W_MAX    = WW'(MIN_PULSE);
  localparam logic [WW-1:0]    W_ARM    = WW'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t        state;
  logic          s;
  logic [WW-1:0] w;
  logic          en_prev;
  logic          accept;
  logic          ack_take;
  logic          en_rise;

  function automatic logic [CNT_W-1:0] pend_sat_inc(input logic [CNT_W-1:0] v);
    return (v == PEND_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] pend_sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  intr_sync u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (INTR),
    .q   (s)
  );

  // Accept on the cycle the width counter is about to reach MIN_PULSE;
  // saturation of w keeps a long pulse from being accepted twice.
  assign accept   = s && (w == W_ARM);
  assign ack_take = (state == ST_REQ) && INT_ACK;
  assign en_rise  = INT_EN && !en_prev;

  // Width qualifier
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w <= '0;
    end else if (!s) begin
      w <= '0;
    end else if (w != W_MAX) begin
      w <= w + 1'b1;
    end
  end

  // Pending counter and overflow flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PEND_CNT <= '0;
      OVF      <= 1'b0;
    end else if (accept && !ack_take) begin
      if (PEND_CNT == PEND_MAX) begin
        OVF <= 1'b1;
      end
      PEND_CNT <= pend_sat_inc(PEND_CNT);
    end else if (ack_take && !accept) begin
      PEND_CNT <= pend_sat_dec(PEND_CNT);
    end
    // accept and ack together cancel out: count and OVF untouched
  end

  // Request/acknowledge FSM with registered IRQ
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      IRQ     <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      en_prev <= INT_EN;
      case (state)
        ST_IDLE: begin
          if ((PEND_CNT != '0) && INT_EN) begin
            state <= ST_REQ;
            IRQ   <= 1'b1;
          end
        end
        ST_REQ: begin
          // ACK wins over a simultaneous enable drop: the CPU has already
          // committed to the interrupt cycle.
          if (INT_ACK) begin
            state <= ST_BUSY;
            IRQ   <= 1'b0;
          end else if (!INT_EN) begin
            state <= ST_IDLE;
            IRQ   <= 1'b0;
          end
        end
        ST_BUSY: begin
          // Leave only on the return-from-interrupt re-enable edge.
          if (en_rise) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          IRQ   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_receiver.sv
// tb_intr_receiver: directed tests for intr_receiver (MIN_PULSE=3, CNT_W=2).
module tb_intr_receiver;

  logic       CLK;
  logic       RST;
  logic       INTR;
  logic       INT_EN;
  logic       INT_ACK;
  logic       IRQ;
  logic [1:0] PEND_CNT;
  logic       OVF;

  int n_checks;
  int n_fail;

  intr_receiver #(.MIN_PULSE(3), .CNT_W(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .INTR     (INTR),
    .INT_EN   (INT_EN),
    .INT_ACK  (INT_ACK),
    .IRQ      (IRQ),
    .PEND_CNT (PEND_CNT),
    .OVF      (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  // Drive an INTR pulse spanning len sampling edges, then let it drain.
  task automatic pulse(input int len);
    INTR = 1'b1;
    repeat (len) tick();
    INTR = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", IRQ); end
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL reset_pend got %0d want 0", PEND_CNT); end
    n_checks++;
    if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", OVF); end
    RST = 1'b0;
  endtask

  // 6-cycle pulse: IRQ at edge 6, ACK at edge 7 clears it.
  task automatic test_single_event();
    do_reset();
    INT_EN = 1'b1;
    tick();
    INTR = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL lat_irq_e5 got %b want 0", IRQ); end
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL lat_pend_e5 got %0d want 1", PEND_CNT); end
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL lat_irq_e6 got %b want 1", IRQ); end
    INTR = 1'b0;
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ack_irq got %b want 0", IRQ); end
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL ack_pend got %0d want 0", PEND_CNT); end
    repeat (6) tick();
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL once_per_pulse got %0d want 0", PEND_CNT); end
  endtask

  task automatic test_glitch();
    do_reset();
    INT_EN = 1'b1;
    pulse(2);
    repeat (2) tick();
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL glitch_pend got %0d want 0", PEND_CNT); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got %b want 0", IRQ); end
    // exactly MIN_PULSE cycles is accepted
    INTR = 1'b1;
    repeat (3) tick();
    INTR = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL min_pulse_pend got %0d want 1", PEND_CNT); end
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL min_pulse_irq got %b want 1", IRQ); end
  endtask

  task automatic test_overflow();
    do_reset();
    INT_EN = 1'b0;
    pulse(6);
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL ack_idle_ignored got %0d want 1", PEND_CNT); end
    pulse(6);
    pulse(6);
    n_checks++;
    if (PEND_CNT !== 2'd3) begin n_fail++; $display("FAIL sat_pend got %0d want 3", PEND_CNT); end
    n_checks++;
    if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", OVF); end
    pulse(6);
    n_checks++;
    if (PEND_CNT !== 2'd3) begin n_fail++; $display("FAIL ovf_pend got %0d want 3", PEND_CNT); end
    n_checks++;
    if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", OVF); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_disabled got %b want 0", IRQ); end
    INT_EN = 1'b1;
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ovf_enable_irq got %b want 1", IRQ); end
  endtask

  // Request withdrawal, then BUSY and return-from-interrupt.
  task automatic test_withdraw_busy();
    do_reset();
    INT_EN = 1'b0;
    pulse(6);
    pulse(6);
    INT_EN = 1'b1;
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL wd_irq_up got %b want 1", IRQ); end
    INT_EN = 1'b0;
    tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL wd_irq_drop got %b want 0", IRQ); end
    n_checks++;
    if (PEND_CNT !== 2'd2) begin n_fail++; $display("FAIL wd_pend got %0d want 2", PEND_CNT); end
    INT_EN = 1'b1;
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL wd_irq_reraise got %b want 1", IRQ); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL busy_pend got %0d want 1", PEND_CNT); end
    tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL busy_hold_irq got %b want 0", IRQ); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL ack_busy_ignored got %0d want 1", PEND_CNT); end
    INT_EN = 1'b0;
    tick();
    INT_EN = 1'b1;
    tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rti_idle_irq got %b want 0", IRQ); end
    tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL rti_irq got %b want 1", IRQ); end
  endtask

  task automatic test_reset_in_req();
    do_reset();
    INT_EN = 1'b0;
    repeat (4) pulse(6);
    INT_EN = 1'b1;
    tick();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    INT_EN = 1'b0;
    tick();
    INT_EN = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({IRQ, PEND_CNT, OVF} !== 4'b1_10_1) begin
      n_fail++; $display("FAIL req_pre_reset got irq=%b pend=%0d ovf=%b want 1/2/1", IRQ, PEND_CNT, OVF);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL async_rst_irq got %b want 0", IRQ); end
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL async_rst_pend got %0d want 0", PEND_CNT); end
    n_checks++;
    if (OVF !== 1'b0) begin n_fail++; $display("FAIL async_rst_ovf got %b want 0", OVF); end
    #1;
    RST = 1'b0;
    tick();
  endtask

  // Accepted event and ACK on the same edge with the counter saturated.
  task automatic test_simultaneous();
    do_reset();
    INT_EN = 1'b0;
    repeat (3) pulse(6);
    INT_EN = 1'b1;
    tick();
    INTR = 1'b1;
    repeat (4) tick();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    INTR = 1'b0;
    n_checks++;
    if (PEND_CNT !== 2'd3) begin n_fail++; $display("FAIL simul_pend got %0d want 3", PEND_CNT); end
    n_checks++;
    if (OVF !== 1'b0) begin n_fail++; $display("FAIL simul_ovf got %b want 0", OVF); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL simul_irq got %b want 0", IRQ); end
    repeat (6) tick();
  endtask

  // A pulse high across reset release is qualified from scratch.
  task automatic test_reset_midpulse();
    INT_EN = 1'b0;
    INTR = 1'b1;
    repeat (6) tick();
    do_reset();
    repeat (4) tick();
    n_checks++;
    if (PEND_CNT !== 2'd0) begin n_fail++; $display("FAIL midpulse_e4 got %0d want 0", PEND_CNT); end
    tick();
    n_checks++;
    if (PEND_CNT !== 2'd1) begin n_fail++; $display("FAIL midpulse_e5 got %0d want 1", PEND_CNT); end
    INTR = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    INTR     = 1'b0;
    INT_EN   = 1'b0;
    INT_ACK  = 1'b0;
    test_reset();
    test_single_event();
    test_glitch();
    test_overflow();
    test_withdraw_busy();
    test_reset_in_req();
    test_simultaneous();
    test_reset_midpulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
